// File: rtl/nios2_pio_pkg.sv
// Shared constants for the Nios II input PIO: register offsets, edge-type codes, bus width.
// Pure definitions, no logic; imported by the PIO top.
package nios2_pio_pkg;

  localparam int PIO_DATA_W = 32;

  localparam logic [1:0] PIO_OFS_DATA    = 2'd0;
  localparam logic [1:0] PIO_OFS_RSVD    = 2'd1;
  localparam logic [1:0] PIO_OFS_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_OFS_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_debounce.sv
// One-bit debounce filter: output follows input only after DEBOUNCE_CYC consecutive differing cycles.
// Adds DEBOUNCE_CYC cycles of latency to a clean transition; no handshake.
module pio_in_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rst_val_i,
  input  logic din_i,
  output logic filt_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Any cycle where the input agrees with the filtered value restarts the count.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (din_i != filt_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        filt_d = din_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= rst_val_i;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/nios2_pio_in_irq.sv
// Avalon-MM input PIO with per-bit edge capture and level irq; debounce compiled in by PIO_IN_DEBOUNCE_EN.
// Read latency 1, no wait states; in_port reaches DATA after SYNC_STAGES (+DEBOUNCE_CYC) + 1 cycles.
module nios2_pio_in_irq
  import nios2_pio_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               EDGE_TYPE    = EDGE_RISE,
  parameter int               SYNC_STAGES  = 2,
  parameter int               DEBOUNCE_CYC = 16,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [WIDTH-1:0]      in_port,
  output logic [PIO_DATA_W-1:0] readdata,
  output logic                  irq
);

  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYC < 1) begin : g_bad_param
    $error("nios2_pio_in_irq: parameter out of range");
  end

  logic [WIDTH-1:0]      sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]      filt, prev_q, rise, fall, edge_det, clr;
  logic [WIDTH-1:0]      irqmask_q, irqmask_d, edgecap_q, edgecap_d;
  logic [PIO_DATA_W-1:0] readdata_q, readdata_d;
  logic                  irq_q, irq_d, wr_en;
  logic                  unused_wdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RESET_VAL;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  for (genvar b = 0; b < WIDTH; b++) begin : g_deb
    pio_in_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
      .clk       (clk),
      .reset_n   (reset_n),
      .rst_val_i (RESET_VAL[b]),
      .din_i     (sync_q[SYNC_STAGES-1][b]),
      .filt_o    (filt[b])
    );
  end
`else
  assign filt = sync_q[SYNC_STAGES-1];
`endif

  assign rise  = filt & ~prev_q;
  assign fall  = ~filt & prev_q;
  assign wr_en = chipselect & ~write_n;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_det = fall;
      EDGE_ANY:  edge_det = rise | fall;
      default:   edge_det = rise;
    endcase
  end

  // A W1C landing on the same cycle as a new edge must not lose that edge, so set is OR'd in last.
  always_comb begin
    irqmask_d = irqmask_q;
    clr       = '0;
    if (wr_en && address == PIO_OFS_IRQMASK) irqmask_d = writedata[WIDTH-1:0];
    if (wr_en && address == PIO_OFS_EDGECAP) clr = writedata[WIDTH-1:0];
    edgecap_d  = (edgecap_q & ~clr) | edge_det;
    irq_d      = |(edgecap_q & irqmask_q);
    readdata_d = '0;
    case (address)
      PIO_OFS_DATA:    readdata_d[WIDTH-1:0] = filt;
      PIO_OFS_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      PIO_OFS_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:         readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q     <= RESET_VAL;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_q     <= filt;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata     = readdata_q;
  assign irq          = irq_q;
  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_nios2_pio_in_irq.sv
// Bench for nios2_pio_in_irq (WIDTH=8, rising edges): reads push expected readdata/irq into a queue,
// a monitor pops and compares one cycle after each read is sampled.
module tb_nios2_pio_in_irq;

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int DEB = 16;
`else
  localparam int DEB = 0;
`endif

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  logic        rd_req;
  logic        rd_vld;
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  nios2_pio_in_irq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: read response with no expected entry, readdata=%08h", readdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks += 2;
        if (readdata !== e.rd) begin
          errors++;
          $display("FAIL %s readdata: got %08h expected %08h", e.name, readdata, e.rd);
        end
        if (irq !== e.irq) begin
          errors++;
          $display("FAIL %s irq: got %b expected %b", e.name, irq, e.irq);
        end
      end
    end
  end

  task automatic rd(input logic [1:0] a, input string nm, input logic [31:0] e_rd, input logic e_irq);
    exp_t e;
    e.name = nm;
    e.rd   = e_rd;
    e.irq  = e_irq;
    exp_q.push_back(e);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    rd_req     = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    rd_req     = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    chipselect = 1'b0;
    write_n    = 1'b1;
    rd_req     = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    in_port    = 8'hFF;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    rd_req     = 1'b0;
    rd_vld     = 1'b0;
    @(negedge clk);

    // Reset held three cycles with inputs high; reads during reset return zero.
    rd(2'd0, "rst_data", 32'h0, 1'b0);
    rd(2'd2, "rst_mask", 32'h0, 1'b0);
    rd(2'd3, "rst_cap",  32'h0, 1'b0);
    reset_n = 1'b1;
    in_port = 8'h00;
    rd(2'd2, "post_rst_mask", 32'h0, 1'b0);
    rd(2'd3, "post_rst_cap",  32'h0, 1'b0);
    idle(4 + DEB);

    // Data path latency: SYNC_STAGES then one readdata cycle.
    in_port = 8'hA5;
    rd(2'd0, "data_lat1", 32'h0, 1'b0);
    idle(DEB);
    rd(2'd0, "data_lat2", 32'h0, 1'b0);
    rd(2'd0, "data_a5",   32'h0000_00A5, 1'b0);
    idle(2);
    rd(2'd3, "cap_a5", 32'h0000_00A5, 1'b0);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, "cap_clr_all", 32'h0, 1'b0);

    // Rising-edge interrupt on bit0.
    wr(2'd2, 32'h0000_0001);
    rd(2'd2, "mask_01", 32'h0000_0001, 1'b0);
    in_port = 8'hA4;
    idle(4 + DEB);
    rd(2'd3, "fall_b0_nocap", 32'h0, 1'b0);
    in_port = 8'hA5;
    rd(2'd3, "rise_b0_t1", 32'h0, 1'b0);
    idle(DEB);
    rd(2'd3, "rise_b0_t2", 32'h0, 1'b0);
    rd(2'd3, "rise_b0_t3", 32'h0, 1'b0);
    rd(2'd3, "rise_b0_cap", 32'h0000_0001, 1'b1);
    wr(2'd3, 32'h0000_0001);
    rd(2'd3, "w1c_b0", 32'h0, 1'b0);
    in_port = 8'hA4;
    idle(4 + DEB);
    rd(2'd3, "fall_b0_nocap2", 32'h0, 1'b0);

    // W1C of bit2 coincides with bit2's rising edge: the edge survives.
    in_port = 8'hA0;
    idle(4 + DEB);
    rd(2'd3, "fall_b2_nocap", 32'h0, 1'b0);
    in_port = 8'hA4;
    idle(2 + DEB);
    wr(2'd3, 32'h0000_0004);
    rd(2'd3, "collide_b2", 32'h0000_0004, 1'b0);
    wr(2'd3, 32'h0000_0004);
    rd(2'd3, "clr_b2", 32'h0, 1'b0);

    // Mask gating, writes to DATA/reserved ignored, upper bits zero.
    wr(2'd2, 32'h0);
    in_port = 8'hB4;
    idle(4 + DEB);
    rd(2'd3, "cap_b4_masked", 32'h0000_0010, 1'b0);
    wr(2'd2, 32'h0000_0010);
    rd(2'd2, "unmask_b4", 32'h0000_0010, 1'b1);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, "rsvd_reads0", 32'h0, 1'b1);
    rd(2'd0, "data_after_wr", 32'h0000_00B4, 1'b1);
    wr(2'd2, 32'hFFFF_FF10);
    rd(2'd2, "mask_upper_ign", 32'h0000_0010, 1'b1);
    wr(2'd2, 32'h0);
    rd(2'd2, "remask_irq_off", 32'h0, 1'b0);
    wr(2'd2, 32'h0000_0010);
    rd(2'd2, "unmask_again", 32'h0000_0010, 1'b1);

    // Reset mid-operation clears mask, capture and irq.
    reset_n = 1'b0;
    rd(2'd2, "midrst_mask", 32'h0, 1'b0);
    rd(2'd3, "midrst_cap",  32'h0, 1'b0);
    reset_n = 1'b1;
    in_port = 8'h00;
    idle(4 + DEB);
    rd(2'd2, "after_midrst_mask", 32'h0, 1'b0);
    rd(2'd3, "after_midrst_cap",  32'h0, 1'b0);
    rd(2'd0, "after_midrst_data", 32'h0, 1'b0);

`ifdef PIO_IN_DEBOUNCE_EN
    // Short glitch filtered out; a long level passes.
    in_port = 8'h08;
    idle(10);
    in_port = 8'h00;
    idle(40);
    rd(2'd0, "deb_glitch_data", 32'h0, 1'b0);
    rd(2'd3, "deb_glitch_cap",  32'h0, 1'b0);
    in_port = 8'h08;
    idle(22);
    rd(2'd0, "deb_level_data", 32'h0000_0008, 1'b0);
    rd(2'd3, "deb_level_cap",  32'h0000_0008, 1'b0);
`endif

    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never observed, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
